// File: rtl/game_defs.sv
// rtl/game_defs.sv - shared game state encodings, colour constants and opaque-pixel test
package game_defs;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int WIN_FRAMES   = 3600;
  localparam int LEVEL_FRAMES = 600;
  localparam int MIN_OVERLAP  = 4;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2,
    ST_WIN  = 2'd3
  } game_state_t;

  // Black and white are the sprite generators' "nothing drawn here" colours.
  function automatic logic is_opaque(input logic [11:0] colour);
    return (colour > BLACK) && (colour < WHITE);
  endfunction

endpackage

// File: rtl/game_status_ctrl_if.sv
// rtl/game_status_ctrl_if.sv - pixel inputs and race status outputs of game_status_ctrl
interface game_status_ctrl_if;

  logic [9:0]  pix_row;
  logic [9:0]  pix_col;
  logic        video_on;
  logic        start;
  logic [11:0] player_car_in;
  logic [11:0] moving_cars_in;
  logic        game_over_flag;
  logic        win_reset_flag;
  logic        playing;
  logic [15:0] distance;
  logic [2:0]  speed_level;

  modport master (
    output pix_row, pix_col, video_on, start, player_car_in, moving_cars_in,
    input  game_over_flag, win_reset_flag, playing, distance, speed_level
  );

  modport slave (
    input  pix_row, pix_col, video_on, start, player_car_in, moving_cars_in,
    output game_over_flag, win_reset_flag, playing, distance, speed_level
  );

endinterface

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - end-of-frame pulse from pixel position; pix_moved_o only with COLLISION_THRESHOLD_EN
module frame_tick_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_row_i,
  input  logic [9:0] pix_col_i,
`ifdef COLLISION_THRESHOLD_EN
  output logic       pix_moved_o,
`endif
  output logic       eof_o
);

  localparam logic [9:0] LAST_ROW = 10'(V_ACTIVE - 1);
  localparam logic [9:0] LAST_COL = 10'(H_ACTIVE - 1);

  logic at_end;
  logic at_end_q;

  assign at_end = (pix_row_i == LAST_ROW) && (pix_col_i == LAST_COL);

  // Remember last cycle's end-pixel match so a held pixel gives one pulse per frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      at_end_q <= 1'b0;
    end else begin
      at_end_q <= at_end;
    end
  end

  assign eof_o = at_end & ~at_end_q;

`ifdef COLLISION_THRESHOLD_EN
  logic [9:0] row_q;
  logic [9:0] col_q;

  // Previous pixel position, so a pixel held over several clocks is seen once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= pix_row_i;
      col_q <= pix_col_i;
    end
  end

  assign pix_moved_o = (pix_row_i != row_q) || (pix_col_i != col_q);
`endif

endmodule

// File: rtl/game_status_ctrl.sv
// rtl/game_status_ctrl.sv - race state machine: collision, distance, speed level; COLLISION_THRESHOLD_EN enables overlap counting
module game_status_ctrl #(
  parameter int H_ACTIVE     = game_defs::H_ACTIVE,
  parameter int V_ACTIVE     = game_defs::V_ACTIVE,
  parameter int WIN_FRAMES   = game_defs::WIN_FRAMES,
  parameter int LEVEL_FRAMES = game_defs::LEVEL_FRAMES,
  parameter int MIN_OVERLAP  = game_defs::MIN_OVERLAP
) (
  input logic               clk,
  input logic               reset,
  game_status_ctrl_if.slave bus
);

  import game_defs::*;

  // Distance is 16 bits and must never wrap; the overlap counter is 8 bits.
  if (WIN_FRAMES < 1 || WIN_FRAMES > 65535 || LEVEL_FRAMES < 1 || LEVEL_FRAMES > 65535 ||
      MIN_OVERLAP < 1 || MIN_OVERLAP > 255) begin : g_param_check
    $error("game_status_ctrl: parameter out of range");
  end

  localparam logic [15:0] WIN_LAST = 16'(WIN_FRAMES - 1);
  localparam logic [15:0] LVL_LAST = 16'(LEVEL_FRAMES - 1);

  game_state_t state_q, state_d;
  logic [15:0] distance_q, distance_d;
  logic [15:0] lvl_cnt_q, lvl_cnt_d;
  logic [2:0]  level_q, level_d;
  logic        over_q, win_q, playing_q;
  logic        eof;
  logic        hit;
  logic        crash;

  assign hit = bus.video_on & is_opaque(bus.player_car_in) & is_opaque(bus.moving_cars_in);

`ifdef COLLISION_THRESHOLD_EN
  localparam logic [8:0] OVERLAP_LIMIT = 9'(MIN_OVERLAP);

  logic       pix_moved;
  logic       count_hit;
  logic [7:0] overlap_q, overlap_d;

  frame_tick_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_frame_tick (
    .clk         (clk),
    .reset       (reset),
    .pix_row_i   (bus.pix_row),
    .pix_col_i   (bus.pix_col),
    .pix_moved_o (pix_moved),
    .eof_o       (eof)
  );

  assign count_hit = hit & pix_moved;
  assign crash     = count_hit && (({1'b0, overlap_q} + 9'd1) >= OVERLAP_LIMIT);

  // Per-frame overlap count: cleared on race start and at every frame end, saturating
  always_comb begin
    overlap_d = overlap_q;
    if (state_q == ST_IDLE && bus.start) begin
      overlap_d = '0;
    end else if (state_q == ST_RUN) begin
      if (eof) begin
        overlap_d = '0;
      end else if (count_hit && overlap_q != 8'hFF) begin
        overlap_d = overlap_q + 8'd1;
      end
    end
  end

  // Overlap counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overlap_q <= '0;
    end else begin
      overlap_q <= overlap_d;
    end
  end
`else
  frame_tick_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_frame_tick (
    .clk       (clk),
    .reset     (reset),
    .pix_row_i (bus.pix_row),
    .pix_col_i (bus.pix_col),
    .eof_o     (eof)
  );

  assign crash = hit;
`endif

  // Next state, distance and speed level; a crash beats a finishing frame
  always_comb begin
    state_d    = state_q;
    distance_d = distance_q;
    lvl_cnt_d  = lvl_cnt_q;
    level_d    = level_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_RUN;
          distance_d = '0;
          lvl_cnt_d  = '0;
          level_d    = '0;
        end
      end
      ST_RUN: begin
        if (eof) begin
          distance_d = distance_q + 16'd1;
          if (lvl_cnt_q == LVL_LAST) begin
            lvl_cnt_d = '0;
            if (level_q != 3'd7) begin
              level_d = level_q + 3'd1;
            end
          end else begin
            lvl_cnt_d = lvl_cnt_q + 16'd1;
          end
        end
        if (crash) begin
          state_d = ST_OVER;
        end else if (eof && distance_q == WIN_LAST) begin
          state_d = ST_WIN;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State, counters and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      distance_q <= '0;
      lvl_cnt_q  <= '0;
      level_q    <= '0;
      over_q     <= 1'b0;
      win_q      <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      distance_q <= distance_d;
      lvl_cnt_q  <= lvl_cnt_d;
      level_q    <= level_d;
      over_q     <= (state_d == ST_OVER);
      win_q      <= (state_d == ST_WIN);
      playing_q  <= (state_d == ST_RUN);
    end
  end

  assign bus.game_over_flag = over_q;
  assign bus.win_reset_flag = win_q;
  assign bus.playing        = playing_q;
  assign bus.distance       = distance_q;
  assign bus.speed_level    = level_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
// tb/tb_game_status_ctrl.sv - randomized self-checking bench for game_status_ctrl
module tb_game_status_ctrl;

  localparam int WIN_F   = 20;
  localparam int LEVEL_F = 2;
  localparam int MIN_OV  = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  game_status_ctrl_if bus_if ();

  game_status_ctrl #(
    .H_ACTIVE     (640),
    .V_ACTIVE     (480),
    .WIN_FRAMES   (WIN_F),
    .LEVEL_FRAMES (LEVEL_F),
    .MIN_OVERLAP  (MIN_OV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: race progress as plain flags and counts
  bit m_started, m_over, m_won, m_prev_end;
  int m_frames, m_ov, m_prev_row, m_prev_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit drawn(input logic [11:0] c);
    return (c != 12'h000) && (c != 12'hFFF);
  endfunction

  function automatic int exp_level();
    return (m_frames / LEVEL_F > 7) ? 7 : m_frames / LEVEL_F;
  endfunction

  task automatic model_reset();
    m_started = 0; m_over = 0; m_won = 0; m_prev_end = 0;
    m_frames = 0; m_ov = 0; m_prev_row = 0; m_prev_col = 0;
  endtask

  task automatic model_step();
    bit at_end, eof, moved, hit, crash;
    int row, col;
    row    = int'(bus_if.pix_row);
    col    = int'(bus_if.pix_col);
    at_end = (row == 479) && (col == 639);
    eof    = at_end && !m_prev_end;
    moved  = (row != m_prev_row) || (col != m_prev_col);
    hit    = bus_if.video_on && drawn(bus_if.player_car_in) && drawn(bus_if.moving_cars_in);
    if (!m_started) begin
      if (bus_if.start) begin
        m_started = 1; m_frames = 0; m_ov = 0;
      end
    end else if (!m_over && !m_won) begin
      crash = hit;
`ifdef COLLISION_THRESHOLD_EN
      crash = 0;
      if (hit && moved) begin
        crash = (m_ov + 1 >= MIN_OV);
        m_ov  = (m_ov < 255) ? m_ov + 1 : 255;
      end
      if (eof) m_ov = 0;
`endif
      if (eof) m_frames++;
      if (crash) m_over = 1;
      else if (eof && m_frames == WIN_F) m_won = 1;
    end
    m_prev_end = at_end;
    m_prev_row = row;
    m_prev_col = col;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_playing"}, bus_if.playing, m_started && !m_over && !m_won);
    check({tag, "_over"}, bus_if.game_over_flag, m_over);
    check({tag, "_win"}, bus_if.win_reset_flag, m_won);
    check({tag, "_dist"}, bus_if.distance, m_frames);
    check({tag, "_level"}, bus_if.speed_level, exp_level());
  endtask

  task automatic drive(input int row, input int col, input bit vid, input bit st,
                       input logic [11:0] pc, input logic [11:0] mc);
    bus_if.pix_row        = 10'(row);
    bus_if.pix_col        = 10'(col);
    bus_if.video_on       = vid;
    bus_if.start          = st;
    bus_if.player_car_in  = pc;
    bus_if.moving_cars_in = mc;
    model_step();
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic safe_pixel(input bit st);
    int row, col;
    bit vid;
    logic [11:0] pc, mc;
    row = $urandom_range(0, 479);
    col = $urandom_range(0, 639);
    if (row == 479 && col == 639) col = 0;
    pc  = 12'($urandom);
    mc  = 12'($urandom);
    vid = 1;
    case ($urandom_range(0, 4))
      0: pc = 12'h000;
      1: pc = 12'hFFF;
      2: mc = 12'h000;
      3: mc = 12'hFFF;
      default: vid = 0;
    endcase
    drive(row, col, vid, st, pc, mc);
  endtask

  task automatic overlap_pixel(input int row, input int col);
    drive(row, col, 1, 0, 12'h0F0, 12'hF00);
  endtask

  // random pixels, then the frame's last pixel held for 1..3 clocks
  task automatic run_frame(input int npix, input bit st, input int crash_odds);
    int hold;
    for (int i = 0; i < npix; i++) begin
      if (crash_odds > 0 && $urandom_range(1, crash_odds) == 1)
        overlap_pixel($urandom_range(0, 478), $urandom_range(0, 639));
      else
        safe_pixel(st);
    end
    hold = $urandom_range(1, 3);
    for (int i = 0; i < hold; i++) drive(479, 639, 1, st, 12'h000, 12'($urandom));
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_playing", bus_if.playing, 0);
    check("rst_over", bus_if.game_over_flag, 0);
    check("rst_win", bus_if.win_reset_flag, 0);
    check("rst_dist", bus_if.distance, 0);
    check("rst_level", bus_if.speed_level, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    bus_if.pix_row = '0; bus_if.pix_col = '0; bus_if.video_on = 0; bus_if.start = 0;
    bus_if.player_car_in = '0; bus_if.moving_cars_in = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // idle: overlaps and frames are ignored before start
    overlap_pixel(200, 300);
    run_frame(5, 0, 0);
    check_all("idle");

    // start pulse, then ten clean frames
    drive(10, 10, 0, 1, 12'h000, 12'h000);
    for (int f = 0; f < 10; f++) run_frame($urandom_range(3, 12), 0, 0);
    check("ten_dist", bus_if.distance, 10);
    check("ten_playing", bus_if.playing, 1);
    check("ten_over", bus_if.game_over_flag, 0);

    // finish the race, level saturates, start presses afterwards change nothing
    for (int f = 10; f < WIN_F; f++) run_frame($urandom_range(2, 8), 0, 0);
    check("win_flag", bus_if.win_reset_flag, 1);
    check("win_dist", bus_if.distance, WIN_F);
    check("win_level", bus_if.speed_level, 7);
    for (int f = 0; f < 3; f++) run_frame(4, 1, 0);
    check_all("win_hold");

    // single overlap mid-race, then frozen distance
    do_reset();
    drive(0, 0, 0, 1, 12'h000, 12'h000);
    for (int f = 0; f < 3; f++) run_frame(5, 0, 0);
    overlap_pixel(200, 300);
    run_frame(5, 0, 0);
    run_frame(5, 1, 0);
    check_all("hit_after");

    // overlap on the final eof pixel; start held through reset release
    bus_if.start = 1;
    do_reset();
    drive(5, 5, 0, 1, 12'h000, 12'h000);
    check("start_held", bus_if.playing, 1);
    for (int f = 0; f < WIN_F - 1; f++) run_frame(2, 0, 0);
    drive(479, 639, 1, 0, 12'h0F0, 12'hF00);
    check_all("final_eof");
    run_frame(3, 0, 0);

`ifdef COLLISION_THRESHOLD_EN
    do_reset();
    drive(0, 0, 0, 1, 12'h000, 12'h000);
    for (int i = 0; i < 3; i++) begin overlap_pixel(100, 10 + i); overlap_pixel(100, 10 + i); end
    run_frame(2, 0, 0);
    for (int i = 0; i < 3; i++) overlap_pixel(120, 20 + i);
    run_frame(2, 0, 0);
    check_all("thr_three");
    for (int i = 0; i < 4; i++) overlap_pixel(140, 30 + i);
    safe_pixel(0);
    check_all("thr_four");
`endif

    // random races with occasional crashes, async reset mid-frame between them
    for (int r = 0; r < 6; r++) begin
      do_reset();
      drive(0, 0, 0, 1, 12'h000, 12'h000);
      for (int f = 0; f < WIN_F + 3; f++) run_frame($urandom_range(4, 14), $urandom_range(0, 1), 60);
      check_all("race");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_status_ctrl.md
Name: game_status_ctrl

Overview:
- Upstream of the display mux. Decides when the race ends and produces `game_over_flag` and `win_reset_flag` for the mux.
- Watches the player-car and moving-cars pixel streams during active video and flags a collision where both draw a real colour on the same pixel.
- Counts completed frames as race distance and raises the win flag at the finish distance.
- Outputs a speed level for the moving-cars generator.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- WIN_FRAMES, 3600, frames survived to win (about 60 s at 60 Hz).
- LEVEL_FRAMES, 600, frames per speed-level step.
- MIN_OVERLAP, 4, overlap pixels per frame that count as a crash (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pix_row  in  10  current pixel row from the display timing generator (dtg).
- pix_col  in  10  current pixel column from the dtg.
- video_on  in  1  active-video qualifier from the dtg.
- start  in  1  synchronised, debounced start button (level).
- player_car_in  in  12  player-car pixel colour for (pix_row, pix_col).
- moving_cars_in  in  12  moving-cars pixel colour for (pix_row, pix_col).
- game_over_flag  out  1  collision ended the game.
- win_reset_flag  out  1  race finished without collision.
- playing  out  1  high while in RUN.
- distance  out  16  frames survived in the current race.
- speed_level  out  3  difficulty level, 0..7.

Behaviour:
- Reset values: all outputs 0; state IDLE. Async assertion; release is sampled on the next clk edge.
- Opaque pixel rule: a colour is opaque when it is strictly greater than 12'h000 and strictly less than 12'hFFF. Both inputs are evaluated combinationally in the same cycle as pix_row/pix_col.
- hit = video_on & player opaque & moving opaque. hit is meaningful only in RUN.
- eof: one-cycle pulse on the rising edge of (pix_row==V_ACTIVE-1 && pix_col==H_ACTIVE-1). It is edge-detected against a registered copy, so one pulse per frame regardless of how long the pixel is held across clk cycles.
- State machine, encoded 2 bits: IDLE, RUN, OVER, WIN.
  - IDLE -> RUN: on start=1. On entry, clear distance, speed_level and the frame collision latch.
  - RUN -> OVER: hit=1 in any cycle. Transition on the next edge, so the collision latency is 1 cycle.
  - RUN -> WIN: eof with distance==WIN_FRAMES-1 and no hit that cycle.
  - OVER and WIN are terminal. They exit only via reset, because the mux latches both flags.
- RUN, per eof:
  - distance increments by 1.
  - speed_level increments each time distance+1 is a multiple of LEVEL_FRAMES, saturating at 7.
- Simultaneous hit and the final eof in the same cycle: OVER wins. Distance still increments in that cycle.
- Outputs are registered:
  - game_over_flag = (state==OVER).
  - win_reset_flag = (state==WIN).
  - playing = (state==RUN).
  - The two flags are never high together.
- start is ignored outside IDLE. A start held through reset release enters RUN one cycle after release.
- distance does not wrap: WIN_FRAMES is at most 65535, and the counter freezes in OVER/WIN.

Optional Feature:
- COLLISION_THRESHOLD_EN defined:
  - An 8-bit overlap counter counts hit pixels within the current frame, saturating at 255.
  - A clk cycle is counted only when (pix_row,pix_col) differs from the previous cycle.
  - RUN -> OVER when the counter reaches MIN_OVERLAP.
  - The counter clears on eof and on IDLE -> RUN.
- Not defined: a single hit pixel ends the game (behaviour above), and no counter logic exists.

Decomposition:
- Shared package/header `game_defs`: the state encodings, the BLACK (12'h000) and WHITE (12'hFFF) colour constants, H_ACTIVE/V_ACTIVE, and an opaque-test function shared with the display mux.
- One sub-module: `frame_tick_gen`, covering the pix_row/pix_col registering and eof edge detection. It is reused by the moving-cars block.

Test Plan:
- Reset then start pulse; 10 frames with no overlap -> playing=1, distance=10, speed_level=0, both flags 0.
- WIN_FRAMES=5, no overlap for 5 frames -> win_reset_flag rises 1 cycle after the 5th eof, distance=5, game_over_flag stays 0. Further start presses cause no change.
- In RUN, player=12'h0F0 and moving=12'hF00 at pixel (200,300) with video_on=1 -> game_over_flag=1 the next cycle, distance frozen. The same overlap with video_on=0, or with either colour 12'hFFF, -> no transition.
- Overlap on the same cycle as the final eof -> OVER, not WIN, and distance=WIN_FRAMES.
- LEVEL_FRAMES=2, 20 frames -> speed_level steps every 2 frames and saturates at 7 after the 14th frame. Reset asserted mid-frame -> all outputs 0 immediately, asynchronously.
- With COLLISION_THRESHOLD_EN and MIN_OVERLAP=4: 3 overlap pixels in a frame -> stays RUN; 4 pixels -> OVER. 3 pixels in each of two consecutive frames -> stays RUN.
